conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

- Producer-side front end for the single-layer 3×3 convolution unit.
- On `start`, it latches nine kernel weights in parallel and emits them serially on `weight_out`/`weight_valid`.
- It then turns a raster-order pixel stream into parallel 3×3 windows on `window_out`/`window_valid`.
- It drives the convolution unit's weight and window inputs directly; those inputs have no backpressure, so this block has none either.

## Interface

Parameters:
- `DataWidth`, 32, bits per pixel/weight (opaque word, no arithmetic)
- `KernelSize`, 9, window elements; fixed 3×3, other values unsupported
- `ImgWidth`, 28, pixels per row, ≥3
- `ImgHeight`, 28, rows per frame, ≥3

Ports:
- `Clk`  in  1  clock
- `Rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse: begin frame; honoured only in IDLE
- `weight_load_in`  in  KernelSize*DataWidth  parallel weights, slot k at bits [k*DataWidth +: DataWidth]; sampled on accepted `start`
- `pixel_in`  in  DataWidth  raster pixel
- `pixel_valid`  in  1  pixel present; accepted only in STREAM
- `weight_out`  out  DataWidth  serial weight
- `weight_valid`  out  1  `weight_out` valid
- `window_out`  out  KernelSize*DataWidth  3×3 window
- `window_valid`  out  1  `window_out` valid, one-cycle pulse per window
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse: last window of frame issued

## Operation

- **Ordering:**
  - Window element (r,c), r=0 top/oldest row, c=0 left/oldest column, occupies slot 3r+c (LSB slot = (0,0)).
  - Weights are emitted slot 0 first, slot 8 last.
  - Slot k of the window therefore pairs with the k-th emitted weight.
- **IDLE** (after reset): outputs inactive; `pixel_valid` ignored.
  - `start` → latch weights, clear counters, go to WEIGHTS.
- **WEIGHTS:** exactly 9 consecutive cycles, `weight_valid`=1, `weight_out`=slot k on the k-th cycle.
  - Then STREAM. No gap, no repeat.
  - `pixel_valid` ignored.
- **STREAM:** each cycle with `pixel_valid`=1 accepts one pixel and advances col (0..ImgWidth-1, wraps to 0 and increments row).
  - Two line buffers of depth ImgWidth hold rows row-1 and row-2.
  - A 3×3 shift register shifts left by one column per accepted pixel. The new right column is {line2 out, line1 out, pixel_in} for rows 0, 1, 2.
  - Window emitted when the accepted pixel has row≥2 and col≥2.
  - Windows per frame: (ImgHeight-2)·(ImgWidth-2).
  - Windows are never formed across a row wrap: the col≥2 gate masks the two stale columns.
  - Gaps in `pixel_valid`: no state advance, no outputs.
- **End of frame:** acceptance of pixel (ImgHeight-1, ImgWidth-1) → last window + `frame_done`, then IDLE.
- **Boundary rules:**
  - `start` while busy is ignored.
  - `start` in the cycle IDLE is re-entered is honoured next cycle at earliest.
  - Pixels beyond frame end are not accepted (state is IDLE).
- **Output defaults:**
  - `weight_out`=0 whenever `weight_valid`=0.
  - `window_out` holds its last emitted window between pulses.
- **Reset values, asynchronous, any state:** all outputs 0, state IDLE, counters 0, latched weights 0, shift register 0. Line buffer contents are don't-care, because they are never observed before being refilled.

## Timing

- `start` sampled at edge n → WEIGHTS cycles n+1..n+9.
  - `weight_valid` high exactly those 9 cycles.
  - First pixel accepted no earlier than edge n+10.
- All outputs registered.
- `window_valid`, `window_out` and `frame_done` appear in the cycle after the accepting edge (latency 1).
- Throughput: one pixel per cycle, one window per cycle sustained within a row.
- `busy` is high from n+1 through the cycle carrying `frame_done`; it drops the following cycle.

## Structure

- Shared package:
  - state encoding (IDLE, WEIGHTS, STREAM)
  - `KernelDim`=3
  - slot-index helper 3r+c
  - counter widths via $clog2(ImgWidth), $clog2(ImgHeight), $clog2(KernelSize+1)
- Sub-module `line_buffer`:
  - parameters DataWidth and Depth
  - ports: enable-gated shift register/RAM, one in, one out delayed by Depth enables
  - instanced twice, chained

## Test plan

- **Weight serialization:** ImgWidth=ImgHeight=4; `weight_load_in` slots 0..8 = 1..9; pulse `start` → `weight_valid` high 9 cycles with `weight_out` 1,2,…,9; `busy`=1.
- **Window content:** stream pixels 1..16 back-to-back → 4 windows.
  - First window slots 0..8 = 1,2,3,5,6,7,9,10,11.
  - Last window = 6,7,8,10,11,12,14,15,16.
  - `frame_done` coincides with the last window; `busy` falls next cycle.
- **Gapped stream:** same frame with `pixel_valid` toggling 1,0,1,0… → identical 4 windows, each one cycle after its completing pixel.
- **Masking:** 5×5 frame, pixels 1..25 → 9 windows; none begins with slot 0 = 4 or 5 (no cross-row windows); `window_valid` count = 9.
- **Ignored inputs:**
  - `pixel_valid` during IDLE/WEIGHTS → no acceptance.
  - `start` during STREAM → weight sequence does not restart.
  - Pixels after `frame_done` → no windows.
- **Async reset mid-STREAM:** assert `Rst` between clock edges → all outputs 0 immediately. A following `start` with a fresh frame produces correct windows, with no residue from the aborted frame.

Source files
------------

// File: rtl/conv_window_feeder_pkg.sv
// Shared types and helpers for the 3x3 convolution window feeder.
// State encoding, kernel geometry and counter sizing live here.
package conv_window_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WEIGHTS = 2'd1,
        ST_STREAM  = 2'd2
    } state_e;

    localparam int KernelDim = 3;

    // Window element (r,c) lives in slot 3r+c; slot 0 is top-left.
    function automatic int slot_idx(input int r, input int c);
        return KernelDim * r + c;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line: o_data is the word written Depth enables ago.
// Contents are not reset; they are always refilled before being observed.
module line_buffer #(
    parameter int DataWidth = 32,
    parameter int Depth     = 28
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic [DataWidth-1:0] i_data,
    output logic [DataWidth-1:0] o_data
);

    logic [DataWidth-1:0] r_mem [Depth];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < Depth; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_data = r_mem[Depth-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Latches 3x3 kernel weights and emits them serially, then turns a
// raster pixel stream into parallel 3x3 windows for the conv unit.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int KernelSize = 9,
    parameter int ImgWidth   = 28,
    parameter int ImgHeight  = 28
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            start,
    input  logic [KernelSize*DataWidth-1:0] weight_load_in,
    input  logic [DataWidth-1:0]            pixel_in,
    input  logic                            pixel_valid,
    output logic [DataWidth-1:0]            weight_out,
    output logic                            weight_valid,
    output logic [KernelSize*DataWidth-1:0] window_out,
    output logic                            window_valid,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int VecW  = KernelSize * DataWidth;
    localparam int ColW  = cnt_width(ImgWidth);
    localparam int RowW  = cnt_width(ImgHeight);
    localparam int WcntW = cnt_width(KernelSize + 1);

    localparam logic [ColW-1:0]  ColLast  = ColW'(ImgWidth - 1);
    localparam logic [RowW-1:0]  RowLast  = RowW'(ImgHeight - 1);
    localparam logic [WcntW-1:0] WcntLast = WcntW'(KernelSize - 1);
    localparam logic [ColW-1:0]  ColWin   = ColW'(KernelDim - 1);
    localparam logic [RowW-1:0]  RowWin   = RowW'(KernelDim - 1);

    state_e r_state;
    state_e w_state_next;

    logic [VecW-1:0]      r_weights;
    logic [WcntW-1:0]     r_wcnt;
    logic [ColW-1:0]      r_col;
    logic [RowW-1:0]      r_row;
    logic [VecW-1:0]      r_win;
    logic [VecW-1:0]      w_win_next;
    logic [DataWidth-1:0] r_weight_out;
    logic                 r_weight_valid;
    logic [VecW-1:0]      r_window_out;
    logic                 r_window_valid;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [DataWidth-1:0] w_lb1_q;
    logic [DataWidth-1:0] w_lb2_q;
    logic [WcntW-1:0]     w_wcnt_inc;
    logic                 w_start_ok;
    logic                 w_wlast;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_frame_end;

    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_wlast     = (r_wcnt == WcntLast);
    assign w_wcnt_inc  = r_wcnt + WcntW'(1);
    // The frame_done cycle still reads STREAM, so block pixels there.
    assign w_accept    = (r_state == ST_STREAM) && pixel_valid
                         && !r_frame_done;
    assign w_col_last  = (r_col == ColLast);
    assign w_row_last  = (r_row == RowLast);
    assign w_emit      = w_accept && (r_row >= RowWin) && (r_col >= ColWin);
    assign w_frame_end = w_accept && w_col_last && w_row_last;

    line_buffer #(
        .DataWidth (DataWidth),
        .Depth     (ImgWidth)
    ) u_line1 (
        .i_clk  (Clk),
        .i_en   (w_accept),
        .i_data (pixel_in),
        .o_data (w_lb1_q)
    );

    line_buffer #(
        .DataWidth (DataWidth),
        .Depth     (ImgWidth)
    ) u_line2 (
        .i_clk  (Clk),
        .i_en   (w_accept),
        .i_data (w_lb1_q),
        .o_data (w_lb2_q)
    );

    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < KernelDim; r++) begin
            for (int c = 0; c < KernelDim - 1; c++) begin
                w_win_next[slot_idx(r, c)*DataWidth +: DataWidth] =
                    r_win[slot_idx(r, c + 1)*DataWidth +: DataWidth];
            end
        end
        w_win_next[slot_idx(0, 2)*DataWidth +: DataWidth] = w_lb2_q;
        w_win_next[slot_idx(1, 2)*DataWidth +: DataWidth] = w_lb1_q;
        w_win_next[slot_idx(2, 2)*DataWidth +: DataWidth] = pixel_in;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_WEIGHTS;
            end
            ST_WEIGHTS: begin
                if (w_wlast) w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_frame_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_weights      <= '0;
            r_wcnt         <= '0;
            r_weight_out   <= '0;
            r_weight_valid <= 1'b0;
        end else begin
            r_weight_out   <= '0;
            r_weight_valid <= 1'b0;
            if (w_start_ok) begin
                r_weights      <= weight_load_in;
                r_wcnt         <= '0;
                r_weight_out   <= weight_load_in[DataWidth-1:0];
                r_weight_valid <= 1'b1;
            end else if (r_state == ST_WEIGHTS && !w_wlast) begin
                r_wcnt         <= w_wcnt_inc;
                r_weight_out   <=
                    r_weights[int'(w_wcnt_inc)*DataWidth +: DataWidth];
                r_weight_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start_ok) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RowW'(1);
            end else begin
                r_col <= r_col + ColW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_win          <= '0;
            r_window_out   <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_window_valid <= w_emit;
            r_frame_done   <= w_frame_end;
            r_busy         <= (w_state_next != ST_IDLE);
            if (w_accept) r_win <= w_win_next;
            if (w_emit) r_window_out <= w_win_next;
        end
    end

    assign weight_out   = r_weight_out;
    assign weight_valid = r_weight_valid;
    assign window_out   = r_window_out;
    assign window_valid = r_window_valid;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: a 4x4 and a 5x5 instance,
// expected windows computed from pixel coordinates at drive time.
module tb_conv_window_feeder;

    localparam int DW = 32;
    localparam int KS = 9;
    localparam int KW = KS * DW;

    localparam int P_WV   = 0;
    localparam int P_WOUT = 1;
    localparam int P_WINV = 2;
    localparam int P_WIN  = 3;
    localparam int P_BUSY = 4;
    localparam int P_FD   = 5;

    typedef struct {
        logic [KW-1:0] win;
        logic          last;
        int            stamp;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [KW-1:0] wl  = '0;

    logic          a_start = 1'b0;
    logic          a_pv    = 1'b0;
    logic [DW-1:0] a_pix   = '0;
    logic [DW-1:0] a_wout;
    logic          a_wv;
    logic [KW-1:0] a_win;
    logic          a_winv;
    logic          a_busy;
    logic          a_fd;

    logic          b_start = 1'b0;
    logic          b_pv    = 1'b0;
    logic [DW-1:0] b_pix   = '0;
    logic [DW-1:0] b_wout;
    logic          b_wv;
    logic [KW-1:0] b_win;
    logic          b_winv;
    logic          b_busy;
    logic          b_fd;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int wins_a   = 0;
    int wins_b   = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    conv_window_feeder #(
        .DataWidth (DW), .KernelSize (KS),
        .ImgWidth  (4),  .ImgHeight  (4)
    ) u_a (
        .Clk (Clk), .Rst (Rst), .start (a_start),
        .weight_load_in (wl), .pixel_in (a_pix),
        .pixel_valid (a_pv), .weight_out (a_wout),
        .weight_valid (a_wv), .window_out (a_win),
        .window_valid (a_winv), .busy (a_busy),
        .frame_done (a_fd)
    );

    conv_window_feeder #(
        .DataWidth (DW), .KernelSize (KS),
        .ImgWidth  (5),  .ImgHeight  (5)
    ) u_b (
        .Clk (Clk), .Rst (Rst), .start (b_start),
        .weight_load_in (wl), .pixel_in (b_pix),
        .pixel_valid (b_pv), .weight_out (b_wout),
        .weight_valid (b_wv), .window_out (b_win),
        .window_valid (b_winv), .busy (b_busy),
        .frame_done (b_fd)
    );

    task automatic check(input string tag, input logic [KW-1:0] got,
                         input logic [KW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] probe(input int sel, input int what);
        logic [KW-1:0] v;
        v = '0;
        case (what)
            P_WV:    v = KW'(sel == 0 ? a_wv : b_wv);
            P_WOUT:  v = KW'(sel == 0 ? a_wout : b_wout);
            P_WINV:  v = KW'(sel == 0 ? a_winv : b_winv);
            P_WIN:   v = (sel == 0) ? a_win : b_win;
            P_BUSY:  v = KW'(sel == 0 ? a_busy : b_busy);
            default: v = KW'(sel == 0 ? a_fd : b_fd);
        endcase
        return v;
    endfunction

    function automatic logic [KW-1:0] model_win(input int w, input int base,
                                                input int r, input int c);
        logic [KW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[(3*i+j)*DW +: DW] = DW'(base + (r-2+i)*w + (c-2+j));
            end
        end
        return v;
    endfunction

    task automatic drive(input int sel, input logic st, input logic pv,
                         input logic [DW-1:0] px);
        if (sel == 0) begin
            a_start = st; a_pv = pv; a_pix = px;
        end else begin
            b_start = st; b_pv = pv; b_pix = px;
        end
    endtask

    task automatic push_exp(input int sel, input int w, input int h,
                            input int base, input int p);
        exp_t e;
        if (p / w >= 2 && p % w >= 2) begin
            e.win   = model_win(w, base, p / w, p % w);
            e.last  = (p == w * h - 1);
            e.stamp = cyc + 1;
            if (sel == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic check_all_zero(input int sel);
        check("rst_weight_valid", probe(sel, P_WV), '0);
        check("rst_weight_out", probe(sel, P_WOUT), '0);
        check("rst_window_valid", probe(sel, P_WINV), '0);
        check("rst_window_out", probe(sel, P_WIN), '0);
        check("rst_busy", probe(sel, P_BUSY), '0);
        check("rst_frame_done", probe(sel, P_FD), '0);
    endtask

    // Pixels are held valid through IDLE and WEIGHTS and must be ignored.
    task automatic do_weights(input int sel, input int wbase);
        for (int k = 0; k < KS; k++) wl[k*DW +: DW] = DW'(wbase + k);
        @(negedge Clk);
        drive(sel, 1'b0, 1'b1, 32'd77);
        check("busy_idle", probe(sel, P_BUSY), '0);
        @(negedge Clk);
        drive(sel, 1'b1, 1'b1, 32'd78);
        @(negedge Clk);
        drive(sel, 1'b0, 1'b1, 32'd79);
        for (int k = 0; k < KS; k++) begin
            check("weight_valid", probe(sel, P_WV), KW'(1));
            check("weight_out", probe(sel, P_WOUT), KW'(wbase + k));
            check("busy_weights", probe(sel, P_BUSY), KW'(1));
            @(negedge Clk);
        end
        check("weight_valid_end", probe(sel, P_WV), '0);
        check("weight_out_zero", probe(sel, P_WOUT), '0);
        drive(sel, 1'b0, 1'b0, '0);
    endtask

    task automatic run_frame(input int sel, input int w, input int h,
                             input int base, input int gap,
                             input int start_at, input int extra);
        for (int p = 0; p < w * h; p++) begin
            if (p > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge Clk);
                    drive(sel, 1'b0, 1'b0, 32'hdead_beef);
                    check("weight_valid_gap", probe(sel, P_WV), '0);
                end
            end
            @(negedge Clk);
            drive(sel, p == start_at, 1'b1, DW'(base + p));
            check("weight_valid_stream", probe(sel, P_WV), '0);
            push_exp(sel, w, h, base, p);
        end
        @(negedge Clk);
        drive(sel, 1'b0, extra > 0, 32'h1234);
        check("frame_done", probe(sel, P_FD), KW'(1));
        check("busy_at_done", probe(sel, P_BUSY), KW'(1));
        @(negedge Clk);
        check("busy_after_done", probe(sel, P_BUSY), '0);
        repeat (extra) @(negedge Clk);
        drive(sel, 1'b0, 1'b0, '0);
        check("queue_drained", KW'(sel == 0 ? qa.size() : qb.size()), '0);
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            if (a_winv) begin
                wins_a++;
                check("a_window_expected", KW'(qa.size() != 0), KW'(1));
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    check("a_window", a_win, ea.win);
                    check("a_latency", KW'(cyc), KW'(ea.stamp));
                    check("a_frame_done", KW'(a_fd), KW'(ea.last));
                end
            end else begin
                check("a_fd_without_window", KW'(a_fd), '0);
            end
        end
    end

    always @(negedge Clk) begin
        if (!Rst) begin
            if (b_winv) begin
                wins_b++;
                check("b_window_expected", KW'(qb.size() != 0), KW'(1));
                check("b_no_cross_row",
                      KW'(b_win[DW-1:0] == 4 || b_win[DW-1:0] == 5), '0);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    check("b_window", b_win, eb.win);
                    check("b_latency", KW'(cyc), KW'(eb.stamp));
                    check("b_frame_done", KW'(b_fd), KW'(eb.last));
                end
            end else begin
                check("b_fd_without_window", KW'(b_fd), '0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge Clk);
        check_all_zero(0);
        check_all_zero(1);
        Rst = 1'b0;

        // Back-to-back frame with a stray start mid-stream.
        do_weights(0, 1);
        run_frame(0, 4, 4, 1, 0, 5, 3);
        check("a_windows_frame1", KW'(wins_a), KW'(4));

        // Gapped stream: valid toggles every cycle.
        do_weights(0, 11);
        run_frame(0, 4, 4, 1, 1, -1, 2);
        check("a_windows_frame2", KW'(wins_a), KW'(8));

        // 5x5 frame exercises row-wrap masking.
        do_weights(1, 21);
        run_frame(1, 5, 5, 1, 0, -1, 2);
        check("b_window_count", KW'(wins_b), KW'(9));

        // Abort a frame with an asynchronous reset mid-window.
        do_weights(0, 31);
        for (int p = 0; p < 12; p++) begin
            @(negedge Clk);
            drive(0, 1'b0, 1'b1, DW'(50 + p));
            push_exp(0, 4, 4, 50, p);
        end
        @(posedge Clk);
        #2;
        check("a_winv_before_reset", KW'(a_winv), KW'(1));
        Rst = 1'b1;
        #1;
        check_all_zero(0);
        drive(0, 1'b0, 1'b0, '0);
        @(negedge Clk);
        qa.delete();
        @(negedge Clk);
        Rst = 1'b0;

        do_weights(0, 41);
        run_frame(0, 4, 4, 200, 0, -1, 0);
        check("a_windows_total", KW'(wins_a), KW'(13));

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
